// File: rtl/jtframe_scan2x_ctrl.sv
// Line-buffer sequencer for the 2x scan doubler: locks onto the input line
// period, steers write/read banks and addresses, and regenerates a doubled HS.
module jtframe_scan2x_ctrl #(
    parameter int HLEN = 512,
    parameter int AW   = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          base_cen,
    input  logic          basex2_cen,
    input  logic          HS,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          wr_bank,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          rd_bank,
    output logic          x2_second,
    output logic          x2_HS,
    output logic          locked,
    output logic [AW-1:0] line_len
);

    typedef enum logic [1:0] {
        SYNC,
        MEASURE,
        CHECK,
        LOCKED
    } state_t;

    localparam logic [AW-1:0] CMAX = '1;
    localparam logic [AW-1:0] ONE  = AW'(1);

    state_t        state, state_nx;
    logic          hs_l;
    logic          hs_rise;
    logic          hs_fall;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt1;
    logic          cnt_sat;
    logic [AW-1:0] hw_cnt;
    logic [AW-1:0] hs_wid;
    logic [AW-1:0] len_q, len_nx;
    logic [AW-1:0] line_len_nx;
    logic          locked_nx;
    logic          in_win;
    logic [AW-1:0] rd_addr_nx;
    logic          second_nx;

    assign hs_rise = base_cen & HS & ~hs_l;
    assign hs_fall = base_cen & ~HS & hs_l;
    assign cnt_sat = (cnt == CMAX);
    assign cnt1    = cnt + ONE;

    // Line tick counter, HS width measurement and write bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_l    <= 1'b0;
            cnt     <= '0;
            hw_cnt  <= '0;
            hs_wid  <= '0;
            wr_bank <= 1'b0;
        end else if (base_cen) begin
            hs_l <= HS;
            if (hs_rise) begin
                cnt     <= '0;
                hw_cnt  <= ONE;
                wr_bank <= ~wr_bank;
            end else begin
                if (!cnt_sat) cnt <= cnt1;
                if (HS && hs_l && hw_cnt != CMAX) hw_cnt <= hw_cnt + ONE;
            end
            if (hs_fall) hs_wid <= hw_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SYNC;
            len_q    <= '0;
            line_len <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= state_nx;
            len_q    <= len_nx;
            line_len <= line_len_nx;
            locked   <= locked_nx;
        end
    end

    // A saturated counter means HS was lost: fall back to SYNC at once
    always_comb begin
        state_nx    = state;
        len_nx      = len_q;
        line_len_nx = line_len;
        locked_nx   = locked;
        if (cnt_sat) begin
            locked_nx = 1'b0;
            state_nx  = hs_rise ? MEASURE : SYNC;
        end else if (hs_rise) begin
            unique case (state)
                SYNC: state_nx = MEASURE;
                MEASURE: begin
                    state_nx = CHECK;
                    len_nx   = cnt1;
                end
                CHECK: begin
                    if (cnt1 == len_q) begin
                        state_nx    = LOCKED;
                        locked_nx   = 1'b1;
                        line_len_nx = len_q;
                    end else begin
                        len_nx = cnt1;
                    end
                end
                LOCKED: begin
                    if (cnt1 != line_len) begin
                        state_nx  = CHECK;
                        locked_nx = 1'b0;
                        len_nx    = cnt1;
                    end
                end
                default: state_nx = SYNC;
            endcase
        end
    end

    generate
        if (HLEN >= 2**AW) begin : g_full
            assign in_win = 1'b1;
        end else begin : g_part
            assign in_win = (cnt < AW'(HLEN));
        end
    endgenerate

    assign wr_en   = base_cen & (state != SYNC) & in_win;
    assign wr_addr = cnt;
    assign rd_bank = ~wr_bank;

    // Read side follows the lock decision taken in this same cycle
    always_comb begin
        rd_addr_nx = rd_addr;
        second_nx  = x2_second;
        if (!locked_nx) begin
            rd_addr_nx = '0;
            second_nx  = 1'b0;
        end else if (basex2_cen) begin
            if (hs_rise) begin
                rd_addr_nx = '0;
                second_nx  = 1'b0;
            end else if (rd_addr == line_len - ONE) begin
                rd_addr_nx = '0;
                second_nx  = ~x2_second;
            end else begin
                rd_addr_nx = rd_addr + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            x2_second <= 1'b0;
            x2_HS     <= 1'b0;
        end else begin
            rd_en     <= locked_nx & basex2_cen;
            rd_addr   <= rd_addr_nx;
            x2_second <= second_nx;
            x2_HS     <= locked_nx & (rd_addr_nx < hs_wid);
        end
    end

endmodule

// File: tb/tb_jtframe_scan2x_ctrl.sv
// Bench for jtframe_scan2x_ctrl: scenario table plus random line periods,
// checked against a line-history model of lock and read-pass behaviour.
module tb_jtframe_scan2x_ctrl;

    localparam int AW   = 9;
    localparam int HLEN = 512;
    localparam int CMAX = 511;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          base_cen;
    logic          basex2_cen;
    logic          HS;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_bank;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_bank;
    logic          x2_second;
    logic          x2_HS;
    logic          locked;
    logic [AW-1:0] line_len;

    jtframe_scan2x_ctrl #(.HLEN(HLEN), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .base_cen   (base_cen),
        .basex2_cen (basex2_cen),
        .HS         (HS),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_bank    (wr_bank),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_bank    (rd_bank),
        .x2_second  (x2_second),
        .x2_HS      (x2_HS),
        .locked     (locked),
        .line_len   (line_len)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Model state: line periods seen since the last loss of sync
    int m_cnt, m_hl, m_bank, m_started, m_locked, m_len;
    int m_wid, m_run, m_k;
    int per[$];

    typedef struct {
        int period;
        int wid;
        int lines;
        bit exp_locked;
        int exp_len;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_hl = 0; m_bank = 0; m_started = 0;
        m_locked = 0; m_len = 0; m_wid = 0; m_run = 0; m_k = 0;
        per.delete();
    endtask

    task automatic check_read(input string tag, input bit pulse);
        int a, s, x, e;
        a = 0; s = 0; x = 0; e = 0;
        if (m_locked != 0) begin
            a = m_k % m_len;
            s = (m_k / m_len) % 2;
            x = (a < m_wid) ? 1 : 0;
            e = pulse ? 1 : 0;
        end
        chk({tag, "_rd_en"}, rd_en, e);
        chk({tag, "_rd_addr"}, rd_addr, a);
        chk({tag, "_x2_second"}, x2_second, s);
        chk({tag, "_x2_HS"}, x2_HS, x);
    endtask

    task automatic base_tick(input logic h);
        bit rise, fall;
        @(negedge clk);
        base_cen = 1'b1; basex2_cen = 1'b1; HS = h;
        #1;
        chk("wr_en", wr_en, (m_started != 0 && m_cnt < HLEN) ? 1 : 0);
        chk("wr_addr", wr_addr, m_cnt);
        chk("wr_bank", wr_bank, m_bank);
        chk("rd_bank", rd_bank, 1 - m_bank);
        rise = h && (m_hl == 0);
        fall = !h && (m_hl != 0);
        if (rise) begin
            if (m_started != 0) begin
                per.push_back(m_cnt + 1);
                if (per.size() > 2) void'(per.pop_front());
            end
            m_started = 1;
            m_locked = (per.size() == 2 && per[0] == per[1]) ? 1 : 0;
            if (m_locked != 0) m_len = per[1];
            m_bank = 1 - m_bank;
        end
        m_cnt = rise ? 0 : ((m_cnt < CMAX) ? m_cnt + 1 : m_cnt);
        m_k = rise ? 0 : m_k + 1;
        @(posedge clk); #1;
        check_read("e0", 1'b1);
        if (rise) m_run = 1;
        else if (h && m_hl != 0) begin
            if (m_run < CMAX) m_run++;
        end else if (fall) m_wid = m_run;
        m_hl = h ? 1 : 0;
        @(negedge clk);
        base_cen = 1'b0; basex2_cen = 1'b0;
        @(posedge clk); #1;
        if (m_cnt == CMAX) begin
            m_locked = 0;
            m_started = 0;
            per.delete();
        end
        chk("locked", locked, m_locked);
        chk("line_len", line_len, m_len);
        check_read("e1", 1'b0);
        @(negedge clk);
        basex2_cen = 1'b1;
        m_k++;
        @(posedge clk); #1;
        check_read("e2", 1'b1);
        @(negedge clk);
        basex2_cen = 1'b0;
    endtask

    task automatic run_line(input int period, input int wid);
        for (int t = 0; t < period; t++) base_tick(t < wid);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_bank"}, wr_bank, 0);
        chk({tag, "_rd_bank"}, rd_bank, 1);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_x2_second"}, x2_second, 0);
        chk({tag, "_x2_HS"}, x2_HS, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_line_len"}, line_len, 0);
    endtask

    initial begin
        int p, w, n;
        tbl[0] = '{384, 32, 3, 1'b1, 384};
        tbl[1] = '{380, 32, 2, 1'b0, 384};
        tbl[2] = '{380, 32, 1, 1'b1, 380};
        tbl[3] = '{520, 40, 1, 1'b0, 380};
        tbl[4] = '{520, 40, 2, 1'b0, 380};
        tbl[5] = '{300, 20, 2, 1'b0, 380};
        tbl[6] = '{300, 20, 1, 1'b1, 300};

        rst_n = 1'b0; base_cen = 1'b1; basex2_cen = 1'b1; HS = 1'b1;
        #12;
        check_all_zero("por");
        @(negedge clk);
        base_cen = 1'b0; basex2_cen = 1'b0; HS = 1'b0;
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 7; i++) begin
            for (int l = 0; l < tbl[i].lines; l++) run_line(tbl[i].period, tbl[i].wid);
            chk($sformatf("tbl%0d_locked", i), locked, tbl[i].exp_locked);
            chk($sformatf("tbl%0d_line_len", i), line_len, tbl[i].exp_len);
        end

        // HS stops: counter saturates and lock is lost
        for (int t = 0; t < 600; t++) base_tick(1'b0);
        chk("hs_stop_locked", locked, 0);
        chk("hs_stop_wr_addr", wr_addr, CMAX);
        for (int l = 0; l < 3; l++) run_line(300, 24);
        chk("resume_locked", locked, 1);
        chk("resume_line_len", line_len, 300);

        // Asynchronous reset mid-line while locked
        for (int t = 0; t < 150; t++) base_tick(t < 24);
        chk("pre_rst_locked", locked, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0; base_cen = 1'b1; basex2_cen = 1'b1; HS = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        check_all_zero("midrst_hold");
        @(negedge clk);
        base_cen = 1'b0; basex2_cen = 1'b0; HS = 1'b0;
        rst_n = 1'b1;
        model_reset();

        for (int s = 0; s < 8; s++) begin
            p = $urandom_range(200, 40);
            w = $urandom_range(p / 3, 1);
            n = $urandom_range(3, 1);
            for (int l = 0; l < n; l++) run_line(p, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
